// File: rtl/shifter_right_pipe_if.sv
// shifter_right_pipe_if: operand, control and result bundle for the pipelined right shifter.
interface shifter_right_pipe_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] cout;
  logic             out_valid;
  modport master (
    output A, B, sel, in_valid, stall, flush,
    input  in_ready, cout, out_valid
  );
  modport slave (
    input  A, B, sel, in_valid, stall, flush,
    output in_ready, cout, out_valid
  );
endinterface

// File: rtl/shifter_right_pipe.sv
// shifter_right_pipe: SRL/SRA of A by B[4:0], one stage per shift-amount bit, with stall and flush.
module shifter_right_pipe #(
  parameter int         WIDTH     = 32,
  parameter int         SHAMT_W   = 5,
  parameter logic [5:0] FUNCT_SRA = 6'b000011
) (
  input logic clk,
  input logic reset,
  shifter_right_pipe_if.slave bus
);
  logic [SHAMT_W-1:0]              valid_q, valid_d, src_valid;
  logic [SHAMT_W-1:0][WIDTH-1:0]   data_q, data_d, src_data, shifted;
  logic [SHAMT_W-1:0][SHAMT_W-1:0] amt_q, amt_d, src_amt;
  logic [SHAMT_W-1:0]              fill_q, fill_d, src_fill;
  logic [SHAMT_W-1:0]              arith_q, arith_d, src_arith;
  logic                            arith_in;
  logic                            unused_bits;
  assign arith_in = bus.sel == FUNCT_SRA;
  // Each stage sees the input operand (stage 0) or the previous stage's registers.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.A;
    src_amt[0]   = bus.B[SHAMT_W-1:0];
    src_arith[0] = arith_in;
    src_fill[0]  = arith_in & bus.A[WIDTH-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_arith[k] = arith_q[k-1];
      src_fill[k]  = fill_q[k-1];
    end
  end
  // Stage k conditionally shifts by 2^k, back-filling the vacated top bits with the fill bit.
  always_comb begin
    for (int k = 0; k < SHAMT_W; k++)
      shifted[k] = src_amt[k][k]
        ? ((src_data[k] >> (1 << k)) | ({WIDTH{src_fill[k]}} & ~({WIDTH{1'b1}} >> (1 << k))))
        : src_data[k];
  end
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    arith_d = arith_q;
    if (bus.flush) begin
      valid_d = '0;
    end else if (!bus.stall) begin
      valid_d = src_valid;
      data_d  = shifted;
      amt_d   = src_amt;
      fill_d  = src_fill;
      arith_d = src_arith;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      amt_q   <= '0;
      fill_q  <= '0;
      arith_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      arith_q <= arith_d;
    end
  end
  assign bus.in_ready  = ~bus.stall;
  assign bus.out_valid = valid_q[SHAMT_W-1];
  assign bus.cout      = valid_q[SHAMT_W-1] ? data_q[SHAMT_W-1] : '0;
  assign unused_bits   = ^{bus.B[WIDTH-1:SHAMT_W], amt_q[SHAMT_W-1], fill_q[SHAMT_W-1], arith_q[SHAMT_W-1]};
endmodule

// File: tb/tb_shifter_right_pipe.sv
// tb_shifter_right_pipe: randomized and directed checks of the pipelined right shifter against an
// in-flight queue model where each accepted operation surfaces after 5 advancing edges.
module tb_shifter_right_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [31:0] res;
    int          age;
  } ent_t;
  ent_t q[$];
  logic        ev;
  logic [31:0] ec;
  shifter_right_pipe_if #(.WIDTH(32)) bus ();
  shifter_right_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s);
    int n;
    n = int'(b % 32);
    return (s == 6'b000011) ? 32'($signed(a) >>> n) : (a >> n);
  endfunction
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] s,
                       input logic st, input logic fl);
    @(negedge clk);
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.sel = s;
    bus.stall = st;
    bus.flush = fl;
    @(posedge clk);
    if (reset || fl) q.delete();
    else if (!st) begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age > 5) q.delete(0);
      if (v) q.push_back('{ref_shift(a, b, s), 1});
    end
    #1;
    ev = 1'b0;
    ec = '0;
    foreach (q[i]) if (q[i].age == 5) begin ev = 1'b1; ec = q[i].res; end
  endtask
  task automatic idle();
    drive(1'b0, $urandom, $urandom, 6'($urandom), 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hFFFF_FFFF, 32'd4, 6'b000011, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cout !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d out_valid=%b cout=%h want 0/0", i, bus.out_valid, bus.cout);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'd4, 6'b000010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== (i == 4) || bus.cout !== ((i == 4) ? 32'h0FFF_FFFF : 32'h0)) begin
        failures++;
        $display("FAIL reset_first_latency edge=%0d out_valid=%b cout=%h want %b/%h", i + 1,
                 bus.out_valid, bus.cout, i == 4, (i == 4) ? 32'h0FFF_FFFF : 32'h0);
      end
      idle();
    end
  endtask
  task automatic test_directed();
    logic [31:0] ta[8] = '{32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                           32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h1234_5678};
    logic [31:0] tb[8] = '{32'd4, 32'd4, 32'd31, 32'd31, 32'h0000_0020, 32'd0, 32'hFFFF_FFE4, 32'd31};
    logic [5:0]  ts[8] = '{6'b000010, 6'b000011, 6'b000011, 6'b000010, 6'b000011, 6'b000011,
                           6'b000010, 6'b000011};
    logic [31:0] te[8] = '{32'h0800_000F, 32'hF800_000F, 32'hFFFF_FFFF, 32'h0000_0001,
                           32'h8000_00F0, 32'h8000_00F0, 32'h0800_000F, 32'h0000_0000};
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, ta[t], tb[t], ts[t], 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus.out_valid !== (i == 4) || bus.cout !== ((i == 4) ? te[t] : 32'h0)) begin
          failures++;
          $display("FAIL directed t=%0d edge=%0d out_valid=%b cout=%h want %b/%h", t, i + 1,
                   bus.out_valid, bus.cout, i == 4, (i == 4) ? te[t] : 32'h0);
        end
        idle();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed_one_cycle t=%0d out_valid=%b want 0", t, bus.out_valid);
      end
    end
  endtask
  task automatic test_back_to_back();
    int idx = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) drive(1'b1, 32'hFFFF_0000, 32'(c), 6'b000010, 1'b0, 1'b0);
      else idle();
      checks++;
      if (bus.out_valid !== ev || bus.cout !== ec) begin
        failures++;
        $display("FAIL b2b_model c=%0d got %b/%h want %b/%h", c, bus.out_valid, bus.cout, ev, ec);
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.cout !== (32'hFFFF_0000 >> idx) || c !== idx + 4) begin
          failures++;
          $display("FAIL b2b_order c=%0d idx=%0d cout=%h want %h at c=%0d", c, idx, bus.cout,
                   32'hFFFF_0000 >> idx, idx + 4);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 8) begin
      failures++;
      $display("FAIL b2b_count got %0d want 8", idx);
    end
  endtask
  task automatic test_stall();
    logic [31:0] held_c;
    logic        held_v;
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, (i == 1) ? 6'b000011 : 6'b000010, 1'b0, 1'b0);
    idle();
    idle();
    held_c = bus.cout;
    held_v = bus.out_valid;
    checks++;
    if (held_v !== 1'b1 || held_c !== ec) begin
      failures++;
      $display("FAIL stall_pre got %b/%h want 1/%h", held_v, held_c, ec);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 6'($urandom), 1'b1, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== held_v || bus.cout !== held_c) begin
        failures++;
        $display("FAIL stall_freeze i=%0d in_ready=%b got %b/%h want 0 %b/%h", i, bus.in_ready,
                 bus.out_valid, bus.cout, held_v, held_c);
      end
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== ev || bus.cout !== ec) begin
        failures++;
        $display("FAIL stall_drain i=%0d in_ready=%b got %b/%h want 1 %b/%h", i, bus.in_ready,
                 bus.out_valid, bus.cout, ev, ec);
      end
    end
  endtask
  task automatic test_flush();
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, $urandom, 6'b000011, 1'b0, 1'b0);
    drive(1'b1, $urandom, $urandom, 6'b000011, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cout !== 32'h0) begin
        failures++;
        $display("FAIL flush_drop i=%0d got %b/%h want 0/0", i, bus.out_valid, bus.cout);
      end
      idle();
    end
    drive(1'b1, 32'hF000_0000, 32'd8, 6'b000011, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== (i == 4) || bus.cout !== ((i == 4) ? 32'hFFF0_0000 : 32'h0)) begin
        failures++;
        $display("FAIL flush_next edge=%0d got %b/%h want %b/%h", i + 1, bus.out_valid, bus.cout,
                 i == 4, (i == 4) ? 32'hFFF0_0000 : 32'h0);
      end
      idle();
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom | 32'h1, $urandom, 6'b000010, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.cout !== ec) begin
      failures++;
      $display("FAIL areset_pre got %b/%h want 1/%h", bus.out_valid, bus.cout, ec);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cout !== 32'h0) begin
      failures++;
      $display("FAIL areset_immediate got %b/%h want 0/0", bus.out_valid, bus.cout);
    end
    drive(1'b1, $urandom, $urandom, 6'b000010, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cout !== 32'h0) begin
        failures++;
        $display("FAIL areset_after i=%0d got %b/%h want 0/0", i, bus.out_valid, bus.cout);
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            ($urandom_range(0, 1) != 0) ? 6'b000011 : 6'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 29) == 0));
      checks++;
      if (bus.out_valid !== ev || bus.cout !== ec) begin
        failures++;
        $display("FAIL random c=%0d got %b/%h want %b/%h", c, bus.out_valid, bus.cout, ev, ec);
      end
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.sel = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shifter_right_pipe.md
Name: shifter_right_pipe

Overview:
- Pipelined 32-bit right shifter for the ALU shift path.
- Performs SRL (logical) and SRA (arithmetic) of operand A by B[4:0].
- One pipeline stage per shift-amount bit; accepts one operation per cycle; supports stall and flush from the hazard unit.

Parameters:
- WIDTH, 32, data width of A, B and cout.
- SHAMT_W, 5, number of low bits of B used as the shift amount; also the number of pipeline stages.
- FUNCT_SRA, 6'b000011, sel value that selects arithmetic shift. Any other sel value selects logical shift.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- A  in  WIDTH  operand to shift
- B  in  WIDTH  shift amount; only B[SHAMT_W-1:0] is used, upper bits are ignored
- sel  in  6  function code; FUNCT_SRA = arithmetic, anything else = logical
- in_valid  in  1  A/B/sel are valid this cycle
- in_ready  out  1  block can accept input; equals ~stall
- stall  in  1  freeze the whole pipeline
- flush  in  1  invalidate every in-flight operation
- cout  out  WIDTH  shift result
- out_valid  out  1  cout holds a valid result

Behaviour:
- Clock and reset:
  - One clock, clk. reset is asynchronous and active-high.
  - While reset is high: all stage valid bits = 0, all stage data/amount/mode registers = 0, cout = 0, out_valid = 0.
  - Operation resumes on the first rising edge after reset deasserts.
- Stage structure:
  - Stage k (k = 0..SHAMT_W-1) holds: valid_k, data_k[WIDTH-1:0], remaining shift bits, arith_k.
  - Stage 0 captures the input: data_0 = B[0] ? (A >> 1 with fill) : A.
  - Stage k>0: data_k = B[k] ? (data_{k-1} >> 2^k with fill) : data_{k-1}.
  - Fill bit is A[WIDTH-1] when arithmetic, 0 when logical. Each stage carries the sign bit and mode forward.
- Latency and throughput:
  - Exactly SHAMT_W (5) rising edges from acceptance to out_valid = 1, with no stalls.
  - Throughput is one result per cycle.
- Acceptance:
  - Input is accepted on a rising edge when in_valid = 1, stall = 0 and flush = 0.
  - When in_valid = 0 (with stall = 0), a bubble enters: valid_0 = 0, and the data registers may hold their previous value.
- Stall (stall = 1, flush = 0):
  - Every stage register holds, including out_valid and cout. in_ready = 0. Input is ignored.
- Flush (flush = 1):
  - On the next edge all valid bits clear to 0. Input presented on that edge is dropped.
  - flush has priority over stall.
  - Data registers need not clear, but cout must read 0.
- Output:
  - cout = data_{SHAMT_W-1} when out_valid = 1; otherwise cout = 0.
  - out_valid = valid_{SHAMT_W-1}. There is no backpressure from the consumer; the consumer must use stall.
- Boundary conditions:
  - Shift amount 0 -> cout = A.
  - Shift amount 31, logical -> cout = {31'b0, A[31]}.
  - Shift amount 31, arithmetic -> all bits = A[31].
  - B[31:5] nonzero has no effect (shift amount is taken mod 32).
  - Reset asserted mid-operation discards all in-flight operations immediately; no partial result is ever presented.

Test Plan:
- Reset: assert reset, drive in_valid=1, A=32'hFFFF_FFFF -> cout=0 and out_valid=0 throughout; after deassert, out_valid stays 0 until 5 edges after the first accept.
- Logical: A=32'h8000_00F0, B=4, sel=6'b000010 -> 5 cycles later cout=32'h0800_000F, out_valid=1 for one cycle.
- Arithmetic: A=32'h8000_00F0, B=4, sel=6'b000011 -> cout=32'hF800_000F. Same A with B=31 -> 32'hFFFF_FFFF. Logical with B=31 -> 32'h0000_0001. B=32'h0000_0020 -> cout=A.
- Back-to-back: 8 consecutive accepts, B = 0..7 of A=32'hFFFF_0000 (logical) -> 8 consecutive out_valid cycles with cout = 32'hFFFF_0000 >> n, in order.
- Stall: stall for 3 cycles while 3 operations are in flight -> out_valid/cout frozen and in_ready=0 during the stall; results emerge in order afterwards, each delayed by exactly 3 cycles.
- Flush: flush together with stall and in_valid=1 while 4 operations are in flight -> no out_valid for any of those 5 operations; the next accepted operation appears exactly 5 cycles after its acceptance.
